// File: rtl/hndshk_tx_scheduler.sv
// Source-side scheduler for one four-phase req/ack CDC channel shared by
// NUM_REQ requesters. Requesters are granted round-robin, the winner's word
// is registered onto cdc_data, and each transfer is bounded by an ack timeout
// whose occurrences are counted (saturating) in timeout_count.
module hndshk_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  localparam int ID_W   = $clog2(NUM_REQ),
  localparam int TMR_W  = $clog2(TIMEOUT)
) (
  input  logic                      src_clk,
  input  logic                      src_reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdc_req,
  output logic [DATA_W-1:0]         cdc_data,
  input  logic                      cdc_ack,
  output logic                      done_valid,
  output logic [ID_W-1:0]           done_id,
  output logic                      timeout_err,
  output logic [31:0]               timeout_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ_HI = 2'd1,
    S_ACK_LO = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              via_ack_q, via_ack_d;
  logic              cdc_req_d;
  logic [DATA_W-1:0] cdc_data_d;
  logic              done_valid_d;
  logic [ID_W-1:0]   done_id_d;
  logic              timeout_err_d;
  logic              timeout_hit;

  logic [1:0]        ack_sync;
  logic              ack_s;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   arb_cand;

  // Index arithmetic modulo NUM_REQ; off is always below NUM_REQ.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return sum[ID_W-1:0];
  endfunction

  // Two-flop synchronizer for the asynchronous ack from the destination.
  // NOTE: every clocked block uses non-blocking (<=) so all flops sample the
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge src_clk or negedge src_reset_n) begin
    if (!src_reset_n) ack_sync <= 2'b00;
    else              ack_sync <= {ack_sync[0], cdc_ack};
  end

  assign ack_s = ack_sync[1];

  // Round-robin search: walk from the highest offset down so the last hit,
  // which survives, is the first asserted requester at or after ptr_q.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    arb_cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      arb_cand = wrap_add(ptr_q, unsigned'(k));
      if (req_valid[arb_cand]) begin
        win_found = 1'b1;
        win_idx   = arb_cand;
      end
    end
  end

  // Next-state and output decode for the handshake FSM.
  // NOTE: every signal is given its hold/idle value before the case so no
  // path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    timer_d       = timer_q;
    via_ack_d     = via_ack_q;
    cdc_req_d     = cdc_req;
    cdc_data_d    = cdc_data;
    done_valid_d  = 1'b0;
    done_id_d     = done_id;
    timeout_err_d = 1'b0;
    timeout_hit   = 1'b0;
    req_ready     = '0;

    unique case (state_q)
      S_IDLE: begin
        // A spurious ack_s here is ignored; only REQ_HI looks at it.
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          cdc_data_d         = req_data[int'(win_idx) * DATA_W +: DATA_W];
          id_d               = win_idx;
          ptr_d              = wrap_add(win_idx, 1);
          cdc_req_d          = 1'b1;
          timer_d            = '0;
          state_d            = S_REQ_HI;
        end
      end

      S_REQ_HI: begin
        // Ack wins over a timeout expiring in the same cycle.
        if (ack_s) begin
          cdc_req_d = 1'b0;
          via_ack_d = 1'b1;
          timer_d   = '0;
          state_d   = S_ACK_LO;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          cdc_req_d     = 1'b0;
          via_ack_d     = 1'b0;
          timeout_err_d = 1'b1;
          timeout_hit   = 1'b1;
          done_id_d     = id_q;
          timer_d       = '0;
          state_d       = S_ACK_LO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_ACK_LO: begin
        // No timeout here: the destination must release ack before reuse.
        if (!ack_s) begin
          state_d = S_IDLE;
          if (via_ack_q) begin
            done_valid_d = 1'b1;
            done_id_d    = id_q;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, arbitration pointer and registered channel/status outputs.
  always_ff @(posedge src_clk or negedge src_reset_n) begin
    if (!src_reset_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      timer_q     <= '0;
      via_ack_q   <= 1'b0;
      cdc_req     <= 1'b0;
      cdc_data    <= '0;
      done_valid  <= 1'b0;
      done_id     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      timer_q     <= timer_d;
      via_ack_q   <= via_ack_d;
      cdc_req     <= cdc_req_d;
      cdc_data    <= cdc_data_d;
      done_valid  <= done_valid_d;
      done_id     <= done_id_d;
      timeout_err <= timeout_err_d;
    end
  end

  // Saturating timeout counter, advanced only when a transfer is aborted.
  always_ff @(posedge src_clk or negedge src_reset_n) begin
    if (!src_reset_n)
      timeout_count <= '0;
    else if (timeout_hit && (timeout_count != 32'hFFFF_FFFF))
      timeout_count <= timeout_count + 32'd1;
  end

endmodule

// File: tb/tb_hndshk_tx_scheduler.sv
// Self-checking bench for hndshk_tx_scheduler: table-driven transfers,
// directed corner sequences and a randomized run against a transaction model.
module tb_hndshk_tx_scheduler;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 8;

  typedef struct {
    logic [N-1:0]    valid;
    logic [N*DW-1:0] data;
    int              win;
  } vec_t;

  logic            src_clk = 1'b0;
  logic            src_reset_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            cdc_req;
  logic [DW-1:0]   cdc_data;
  logic            cdc_ack;
  logic            done_valid;
  logic [1:0]      done_id;
  logic            timeout_err;
  logic [31:0]     timeout_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Destination model: 0 = auto four-phase, 1 = ack held low, 2 = ack held high.
  int dest_mode = 0;
  int rise_dly  = 3;
  int fall_dly  = 3;
  int dcnt      = 0;

  hndshk_tx_scheduler #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .src_clk       (src_clk),
    .src_reset_n   (src_reset_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .cdc_req       (cdc_req),
    .cdc_data      (cdc_data),
    .cdc_ack       (cdc_ack),
    .done_valid    (done_valid),
    .done_id       (done_id),
    .timeout_err   (timeout_err),
    .timeout_count (timeout_count)
  );

  always #5 src_clk = ~src_clk;

  // Destination side: follows cdc_req after rise_dly / fall_dly cycles.
  initial begin
    cdc_ack = 1'b0;
    forever begin
      @(posedge src_clk); #1;
      if (dest_mode == 1) begin
        cdc_ack = 1'b0; dcnt = 0;
      end else if (dest_mode == 2) begin
        cdc_ack = 1'b1; dcnt = 0;
      end else if (cdc_req != cdc_ack) begin
        dcnt++;
        if (cdc_req ? (dcnt >= rise_dly) : (dcnt >= fall_dly)) begin
          cdc_ack = cdc_req;
          dcnt    = 0;
        end
      end else begin
        dcnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arbitration: first asserted requester at or after p, with wrap.
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic apply_reset();
    @(negedge src_clk);
    src_reset_n = 1'b0;
    req_valid   = '0;
    repeat (3) @(negedge src_clk);
    src_reset_n = 1'b1;
  endtask

  task automatic wait_accept(input string tag, input int exp_win);
    logic [N-1:0] er;
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge src_clk);
      if (req_ready != '0) begin seen = 1'b1; break; end
    end
    er = '0;
    er[exp_win] = 1'b1;
    check({tag, " accept"}, 64'(seen), 64'd1);
    check({tag, " req_ready"}, 64'(req_ready), 64'(er));
  endtask

  // One complete transfer; data changes after accept must not reach cdc_data.
  task automatic xfer(input string tag, input logic [N-1:0] v,
                      input logic [N*DW-1:0] d, input int exp_win);
    logic [DW-1:0] exp_d;
    bit done, bad, saw_hi, saw_to;
    exp_d = d[exp_win*DW +: DW];
    @(posedge src_clk); #1;
    req_valid = v;
    req_data  = d;
    wait_accept(tag, exp_win);
    @(posedge src_clk); #1;
    req_valid = '0;
    req_data  = ~d;
    done = 0; bad = 0; saw_hi = 0; saw_to = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge src_clk);
      if (cdc_data !== exp_d) bad = 1'b1;
      if (cdc_req) saw_hi = 1'b1;
      if (timeout_err) saw_to = 1'b1;
      if (done_valid) begin done = 1'b1; break; end
    end
    check({tag, " cdc_data held"}, 64'(bad), 64'd0);
    check({tag, " cdc_req seen"}, 64'(saw_hi), 64'd1);
    check({tag, " no timeout"}, 64'(saw_to), 64'd0);
    check({tag, " done_valid"}, 64'(done), 64'd1);
    check({tag, " done_id"}, 64'(done_id), 64'(exp_win));
  endtask

  // Transfer with ack held low: must abort after exactly TO cycles of cdc_req.
  task automatic timeout_run(input string tag, input int id, input logic [31:0] exp_cnt);
    int hi, nto, ndn;
    dest_mode = 1;
    @(posedge src_clk); #1;
    req_valid     = '0;
    req_valid[id] = 1'b1;
    wait_accept(tag, id);
    @(posedge src_clk); #1;
    req_valid = '0;
    hi = 0; nto = 0; ndn = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge src_clk);
      if (cdc_req) hi++;
      if (done_valid) ndn++;
      if (timeout_err) begin
        nto++;
        check({tag, " done_id"}, 64'(done_id), 64'(id));
        check({tag, " timeout_count"}, 64'(timeout_count), 64'(exp_cnt));
      end
    end
    check({tag, " cdc_req cycles"}, 64'(hi), 64'(TO));
    check({tag, " timeout_err pulses"}, 64'(nto), 64'd1);
    check({tag, " no done_valid"}, 64'(ndn), 64'd0);
    dest_mode = 0;
  endtask

  initial begin
    vec_t vecs[7];
    logic [DW-1:0] cur;
    logic [N-1:0]  er;
    int acc, dn, hi, nto, ndn, fall_c, done_c, w, mptr, cur_id, ndone, acc_bit;
    bit bad, busy, prev_hi;

    // Expected winners assume the pointer starts at 0 and advances per row.
    vecs[0] = '{4'b0010, {32'h3, 32'h2, 32'hDEAD_BEEF, 32'h0}, 1};
    vecs[1] = '{4'b0011, {32'h13, 32'h12, 32'h11, 32'h10}, 0};
    vecs[2] = '{4'b1001, {32'h23, 32'h22, 32'h21, 32'h20}, 3};
    vecs[3] = '{4'b1100, {32'h33, 32'h32, 32'h31, 32'h30}, 2};
    vecs[4] = '{4'b0111, {32'h43, 32'h42, 32'h41, 32'h40}, 0};
    vecs[5] = '{4'b0001, {32'h53, 32'h52, 32'h51, 32'h50}, 0};
    vecs[6] = '{4'b1111, {32'h63, 32'h62, 32'h61, 32'h60}, 1};

    src_reset_n = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    #12;
    check("reset req_ready", 64'(req_ready), 64'd0);
    check("reset cdc_req", 64'(cdc_req), 64'd0);
    check("reset cdc_data", 64'(cdc_data), 64'd0);
    check("reset done_valid", 64'(done_valid), 64'd0);
    check("reset done_id", 64'(done_id), 64'd0);
    check("reset timeout_err", 64'(timeout_err), 64'd0);
    check("reset timeout_count", 64'(timeout_count), 64'd0);
    @(negedge src_clk);
    src_reset_n = 1'b1;

    for (int i = 0; i < 7; i++)
      xfer($sformatf("vec%0d", i), vecs[i].valid, vecs[i].data, vecs[i].win);
    check("vectors timeout_count", 64'(timeout_count), 64'd0);

    // Round robin with all requesters held: order 0,1,2,3,0.
    apply_reset();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'h100 + i;
    @(posedge src_clk); #1;
    req_valid = '1;
    acc = 0; dn = 0; bad = 0; cur = '0;
    for (int c = 0; c < 200 && dn < 5; c++) begin
      @(negedge src_clk);
      if (done_valid) begin
        check($sformatf("rr done_id %0d", dn), 64'(done_id), 64'(dn % N));
        dn++;
      end
      if (req_ready != '0) begin
        er = '0;
        er[acc % N] = 1'b1;
        check($sformatf("rr grant %0d", acc), 64'(req_ready), 64'(er));
        cur = 32'h100 + (acc % N);
        acc++;
        if (acc == 5) begin
          @(posedge src_clk); #1;
          req_valid = '0;
        end
      end else if (acc > 0 && cdc_data !== cur) begin
        bad = 1'b1;
      end
    end
    check("rr accepts", 64'(acc), 64'd5);
    check("rr dones", 64'(dn), 64'd5);
    check("rr cdc_data", 64'(bad), 64'd0);

    // Randomized traffic against a transaction-level model.
    apply_reset();
    busy = 0; mptr = 0; cur_id = 0; ndone = 0; acc_bit = -1; bad = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge src_clk); #1;
      rise_dly = $urandom_range(1, 4);
      fall_dly = $urandom_range(1, 4);
      if (acc_bit >= 0) req_valid[acc_bit] = 1'b0;
      acc_bit = -1;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) req_valid[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        req_data[i*DW +: DW] = $urandom;
      end
      @(negedge src_clk);
      if (timeout_err) bad = 1'b1;
      if (done_valid) begin
        check("rand done while busy", 64'(busy), 64'd1);
        check("rand done_id", 64'(done_id), 64'(cur_id));
        busy = 0;
        ndone++;
      end else if (busy) begin
        check("rand cdc_data", 64'(cdc_data), 64'(cur));
      end
      er = '0;
      w  = busy ? -1 : rr_pick(req_valid, mptr);
      if (w >= 0) er[w] = 1'b1;
      check("rand req_ready", 64'(req_ready), 64'(er));
      if (w >= 0) begin
        busy    = 1;
        cur_id  = w;
        cur     = req_data[w*DW +: DW];
        mptr    = (w + 1) % N;
        acc_bit = w;
      end
    end
    @(posedge src_clk); #1;
    req_valid = '0;
    rise_dly  = 3;
    fall_dly  = 3;
    repeat (30) @(negedge src_clk);
    check("rand no timeout", 64'(bad), 64'd0);
    check("rand enough transfers", 64'(ndone >= 10), 64'd1);

    // Timeout, then normal service resumes.
    timeout_run("timeout", 2, 32'd1);
    xfer("after timeout", 4'b0001, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0);

    // Saturation of the timeout counter.
    @(negedge src_clk);
    force dut.timeout_count = 32'hFFFF_FFFE;
    #1;
    release dut.timeout_count;
    #1;
    check("sat preset", 64'(timeout_count), 64'hFFFF_FFFE);
    timeout_run("sat1", 1, 32'hFFFF_FFFF);
    timeout_run("sat2", 3, 32'hFFFF_FFFF);
    check("sat hold", 64'(timeout_count), 64'hFFFF_FFFF);

    // Ack already high before the request: completes after one REQ_HI cycle.
    dest_mode = 2;
    repeat (5) @(negedge src_clk);
    check("spurious ack no grant", 64'(req_ready), 64'd0);
    @(posedge src_clk); #1;
    req_valid = 4'b0100;
    wait_accept("spurious", 2);
    @(posedge src_clk); #1;
    req_valid = '0;
    dest_mode = 0;
    hi = 0; ndn = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge src_clk);
      if (cdc_req) hi++;
      if (done_valid) ndn++;
    end
    check("spurious cdc_req cycles", 64'(hi), 64'd1);
    check("spurious done", 64'(ndn), 64'd1);

    // Ack held high 20 cycles after cdc_req falls: one late done, no timeout.
    rise_dly = 2;
    fall_dly = 20;
    @(posedge src_clk); #1;
    req_valid = 4'b1000;
    wait_accept("stuck", 3);
    @(posedge src_clk); #1;
    req_valid = '0;
    nto = 0; ndn = 0; fall_c = -1; done_c = -1; prev_hi = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge src_clk);
      if (prev_hi && !cdc_req && fall_c < 0) fall_c = c;
      prev_hi = cdc_req;
      if (timeout_err) nto++;
      if (done_valid) begin ndn++; done_c = c; end
    end
    check("stuck no timeout", 64'(nto), 64'd0);
    check("stuck single done", 64'(ndn), 64'd1);
    check("stuck done after ack low", 64'(fall_c >= 0 && done_c - fall_c >= 20), 64'd1);
    fall_dly = 3;

    // Reset in REQ_HI: async drop, no completion, pointer back to 0.
    xfer("pre-reset a", 4'b0010, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1);
    @(posedge src_clk); #1;
    req_valid = 4'b0100;
    wait_accept("pre-reset b", 2);
    @(posedge src_clk); #1;
    req_valid = '0;
    @(negedge src_clk);
    check("pre-reset cdc_req", 64'(cdc_req), 64'd1);
    #1;
    src_reset_n = 1'b0;
    #1;
    check("mid reset cdc_req", 64'(cdc_req), 64'd0);
    check("mid reset cdc_data", 64'(cdc_data), 64'd0);
    check("mid reset done_id", 64'(done_id), 64'd0);
    check("mid reset timeout_count", 64'(timeout_count), 64'd0);
    repeat (2) @(negedge src_clk);
    src_reset_n = 1'b1;
    ndn = 0; nto = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge src_clk);
      if (done_valid) ndn++;
      if (timeout_err) nto++;
    end
    check("post reset no done", 64'(ndn), 64'd0);
    check("post reset no timeout", 64'(nto), 64'd0);
    xfer("post reset ptr0", 4'b1111, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hndshk_tx_scheduler.md
Name: hndshk_tx_scheduler

Overview:
Source-side scheduler that shares one four-phase CDC handshake channel between NUM_REQ requesters. It grants requesters round-robin, registers the winner's word onto the crossing data bus, and runs the req/ack handshake against the destination side. The ack input is synchronized internally. The block bounds each transfer with an ack timeout and keeps a saturating count of timeouts for the verification environment.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 32, width of each data word
TIMEOUT, 255, max cycles in REQ_HI waiting for synchronized ack before abort (>=4)

Ports:
src_clk  input  1  source-domain clock
src_reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester transfer request (level, held until ready)
req_data  input  NUM_REQ*DATA_W  per-requester word; slice i = bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse to the granted requester
cdc_req  output  1  handshake request to destination domain (registered)
cdc_data  output  DATA_W  crossing data bus, stable whenever cdc_req=1 (registered)
cdc_ack  input  1  handshake ack from destination domain (asynchronous)
done_valid  output  1  one-cycle pulse: transfer completed normally
done_id  output  clog2(NUM_REQ)  requester index of completed/aborted transfer
timeout_err  output  1  one-cycle pulse: transfer aborted on timeout
timeout_count  output  32  saturating count of timeouts

Behaviour:
- Reset (async assert, sync deassert handled externally): state=IDLE, cdc_req=0, cdc_data=0, req_ready=0, done_valid=0, done_id=0, timeout_err=0, timeout_count=0, rr pointer=0, timer=0, ack sync flops=0.
- ack_s = cdc_ack after two src_clk flops; all FSM decisions use ack_s only.
- Arbitration (IDLE only): search from index ptr upward with wrap; first asserted req_valid wins. Same cycle: req_ready[win]=1, cdc_data<=slice win, id register<=win, ptr<=win+1 (wrap to 0 after NUM_REQ-1), state<=REQ_HI. No valid: remain IDLE, outputs unchanged.
- REQ_HI: cdc_req=1 (first high cycle is the cycle after accept). timer increments each cycle. If ack_s=1: cdc_req<=0, state<=ACK_LO, timer<=0. Else if timer==TIMEOUT-1: cdc_req<=0, timeout_err pulse, done_id<=id, timeout_count<=count+1 unless already 0xFFFFFFFF, state<=ACK_LO, timer<=0.
- ACK_LO: cdc_req=0. When ack_s=0: state<=IDLE; if entered via ack, done_valid pulse with done_id=id; if entered via timeout, no done_valid. No timeout in ACK_LO (destination must release ack).
- cdc_data holds its value from accept until next accept; never changes while cdc_req=1 or in ACK_LO.
- Back-to-back: IDLE entered after ACK_LO may accept on its first cycle; no extra idle cycle required.
- req_ready pulses only in IDLE; at most one bit set; never asserted for a requester with req_valid=0.
- req_valid dropping before accept is legal (request withdrawn, no accept). Requester changes to req_data after accept have no effect.
- Reset mid-transfer: immediate return to reset values; cdc_req drops asynchronously; in-flight transfer discarded, no done_valid or timeout_err.
- Spurious ack_s=1 in IDLE: ignored; arbitration continues but REQ_HI only completes on ack_s observed in REQ_HI (already-high ack therefore completes immediately — destination misbehaviour, not masked).

Test Plan:
- Single transfer: req_valid=4'b0010, data1=0xDEADBEEF, dest model acks 3 cycles after seeing req, drops 3 cycles after req low -> req_ready=0010 one cycle, cdc_data=0xDEADBEEF, cdc_req high then low, done_valid=1 done_id=1, timeout_count=0.
- Round robin: all four req_valid held, data i=0x100+i -> accept order 0,1,2,3,0, one done_valid per transfer, cdc_data matches each winner throughout its handshake.
- Timeout: req_valid[2]=1, ack tied 0, TIMEOUT=8 -> cdc_req high exactly 8 cycles, timeout_err=1 done_id=2, no done_valid, timeout_count=1, block returns to IDLE and accepts next request.
- Saturation: force 0xFFFFFFFE then two timeouts -> timeout_count=0xFFFFFFFF, stays there.
- Reset mid-handshake: src_reset_n low while in REQ_HI -> cdc_req=0 same cycle (async), all outputs reset values, no done_valid after release; next request accepted from ptr=0.
- Ack stuck high after completion: ack stays high 20 cycles in ACK_LO -> no timeout, no done_valid until ack_s low, then done_valid once.
